// File: rtl/fm_stream_pkg.sv
// Shared constants and helpers for the FM streaming datapath stages.
package fm_stream_pkg;

  localparam int STREAM_DATA_WIDTH = 32;
  localparam int Q10_FRAC_BITS     = 10;

  // Pointer width: address bits plus one wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with level flags, occupancy count and sticky
// overflow/underflow flags; responder end of the wr_en/full, rd_en/empty stream.
module stream_fifo
  import fm_stream_pkg::*;
#(
  parameter int DATA_WIDTH         = STREAM_DATA_WIDTH,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [ptr_width(DEPTH)-1:0]   count,
  input  logic                          clear_err,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);

  // Parameter sanity is checked at elaboration so a bad instance never builds.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end
  if (ALMOST_FULL_LEVEL < 0 || ALMOST_FULL_LEVEL > DEPTH ||
      ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH) begin : g_bad_level
    $error("stream_fifo: almost levels must lie within 0..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_accept, rd_accept;

  // Flags depend only on registered pointers: no path from rd_en/wr_en.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);
  assign dout         = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q && !clear_err;
    underflow_d = underflow_q && !clear_err;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
    // A new error on the same edge as clear_err wins.
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      // NOTE: storage is reset on purpose so dout is never X after bring-up;
      // this keeps the array in flops/LUTRAM-with-reset rather than block RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: vector table, queue scoreboard,
// wrap-around, random traffic and asynchronous reset mid-stream.
module tb_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          rd_en = 1'b0;
  logic          clear_err = 1'b0;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] dout;
  logic [2:0]    count;

  stream_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
    .count(count), .clear_err(clear_err),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] mq[$];
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;

  typedef struct {
    bit            wr, rd, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic [DW-1:0] dout;
    bit            ov, un;
  } vec_t;

  vec_t tab[33];

  function automatic vec_t mk(bit w, bit r, bit c, logic [DW-1:0] d,
                              int n, logic [DW-1:0] o, bit ov, bit un);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.din = d;
    v.cnt = n; v.dout = o; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = mq.size();
    check({tag, " count"},        32'(count),        32'(n));
    check({tag, " empty"},        32'(empty),        32'(n == 0));
    check({tag, " full"},         32'(full),         32'(n == DEPTH));
    check({tag, " almost_full"},  32'(almost_full),  32'(n >= AFL));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
    check({tag, " dout"},         dout,              (n > 0) ? mq[0] : '0);
    check({tag, " overflow"},     32'(overflow),     32'(m_ov));
    check({tag, " underflow"},    32'(underflow),    32'(m_un));
  endtask

  // One clock: drive inputs, pop-check the head on an accepted read, then
  // advance the model and compare every output after the edge.
  task automatic cycle(input bit w, input bit r, input bit c, input logic [DW-1:0] d,
                       input string tag);
    bit full_pre, empty_pre;
    full_pre  = (mq.size() == DEPTH);
    empty_pre = (mq.size() == 0);
    wr_en = w; rd_en = r; clear_err = c; din = d;
    if (r && !empty_pre) check({tag, " sb_head"}, dout, mq[0]);
    @(posedge clock);
    #1;
    if (r && !empty_pre) void'(mq.pop_front());
    if (w && !full_pre)  mq.push_back(d);
    m_ov = (m_ov && !c) || (w && full_pre);
    m_un = (m_un && !c) || (r && empty_pre);
    wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0; din = '0;
    check_outputs(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset, then single write/read, fill, boundary rd+wr and sticky flags.
    tab[0]  = mk(1, 0, 0, 32'hB2, 1, 32'hB2, 0, 0);
    tab[1]  = mk(0, 1, 0, 32'h00, 0, 32'h00, 0, 0);
    tab[2]  = mk(1, 0, 0, 32'h11, 1, 32'h11, 0, 0);
    tab[3]  = mk(1, 0, 0, 32'h22, 2, 32'h11, 0, 0);
    tab[4]  = mk(1, 0, 0, 32'h33, 3, 32'h11, 0, 0);
    tab[5]  = mk(1, 0, 0, 32'h44, 4, 32'h11, 0, 0);
    tab[6]  = mk(1, 0, 0, 32'h55, 4, 32'h11, 1, 0);
    tab[7]  = mk(0, 1, 0, 32'h00, 3, 32'h22, 1, 0);
    tab[8]  = mk(0, 1, 0, 32'h00, 2, 32'h33, 1, 0);
    tab[9]  = mk(0, 1, 0, 32'h00, 1, 32'h44, 1, 0);
    tab[10] = mk(0, 1, 0, 32'h00, 0, 32'h00, 1, 0);
    tab[11] = mk(0, 0, 1, 32'h00, 0, 32'h00, 0, 0);
    tab[12] = mk(1, 0, 0, 32'h01, 1, 32'h01, 0, 0);
    tab[13] = mk(1, 0, 0, 32'h02, 2, 32'h01, 0, 0);
    tab[14] = mk(1, 0, 0, 32'h03, 3, 32'h01, 0, 0);
    tab[15] = mk(1, 0, 0, 32'h04, 4, 32'h01, 0, 0);
    tab[16] = mk(1, 1, 0, 32'h99, 3, 32'h02, 1, 0);
    tab[17] = mk(0, 1, 0, 32'h00, 2, 32'h03, 1, 0);
    tab[18] = mk(0, 1, 0, 32'h00, 1, 32'h04, 1, 0);
    tab[19] = mk(0, 1, 0, 32'h00, 0, 32'h00, 1, 0);
    tab[20] = mk(1, 1, 0, 32'h77, 1, 32'h77, 1, 1);
    tab[21] = mk(0, 1, 0, 32'h00, 0, 32'h00, 1, 1);
    tab[22] = mk(0, 0, 1, 32'h00, 0, 32'h00, 0, 0);
    tab[23] = mk(1, 0, 0, 32'h05, 1, 32'h05, 0, 0);
    tab[24] = mk(1, 0, 0, 32'h06, 2, 32'h05, 0, 0);
    tab[25] = mk(1, 0, 0, 32'h07, 3, 32'h05, 0, 0);
    tab[26] = mk(1, 0, 0, 32'h08, 4, 32'h05, 0, 0);
    tab[27] = mk(1, 0, 1, 32'h09, 4, 32'h05, 1, 0);
    tab[28] = mk(0, 0, 1, 32'h00, 4, 32'h05, 0, 0);
    tab[29] = mk(0, 1, 0, 32'h00, 3, 32'h06, 0, 0);
    tab[30] = mk(0, 1, 0, 32'h00, 2, 32'h07, 0, 0);
    tab[31] = mk(0, 1, 0, 32'h00, 1, 32'h08, 0, 0);
    tab[32] = mk(0, 1, 0, 32'h00, 0, 32'h00, 0, 0);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset empty",        32'(empty),        32'd1);
    check("reset almost_empty", 32'(almost_empty), 32'd1);
    check("reset full",         32'(full),         32'd0);
    check("reset almost_full",  32'(almost_full),  32'd0);
    check("reset count",        32'(count),        32'd0);
    check("reset dout",         dout,              32'd0);
    check("reset overflow",     32'(overflow),     32'd0);
    check("reset underflow",    32'(underflow),    32'd0);

    for (int i = 0; i < 33; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      cycle(tab[i].wr, tab[i].rd, tab[i].clr, tab[i].din, t);
      check({t, " tab_count"},     32'(count),     32'(tab[i].cnt));
      check({t, " tab_dout"},      dout,           tab[i].dout);
      check({t, " tab_overflow"},  32'(overflow),  32'(tab[i].ov));
      check({t, " tab_underflow"}, 32'(underflow), 32'(tab[i].un));
    end

    // Wrap-around: 0x1..0xA, occupancy swinging between 0 and 3.
    w = 1;
    while (w <= 10) begin
      for (int k = 0; k < 3 && w <= 10; k++) begin
        cycle(1, 0, 0, 32'(w), "wrap_wr");
        w++;
      end
      while (mq.size() > 0) cycle(0, 1, 0, '0, "wrap_rd");
    end
    check("wrap overflow",  32'(overflow),  32'd0);
    check("wrap underflow", 32'(underflow), 32'd0);

    // Random mixed traffic against the queue model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), $urandom, "rand");

    // Async reset mid-stream with flags set and three words stored.
    while (mq.size() > 0) cycle(0, 1, 0, '0, "pre_drain");
    cycle(0, 1, 0, '0, "pre_underflow");
    cycle(1, 0, 0, 32'hAA01, "pre_wr");
    cycle(1, 0, 0, 32'hAA02, "pre_wr");
    cycle(1, 0, 0, 32'hAA03, "pre_wr");
    #3 reset = 1'b1;
    #1;
    check("async empty",     32'(empty),     32'd1);
    check("async count",     32'(count),     32'd0);
    check("async dout",      dout,           32'd0);
    check("async overflow",  32'(overflow),  32'd0);
    check("async underflow", 32'(underflow), 32'd0);
    mq.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    check_outputs("post_reset");
    cycle(1, 0, 0, 32'hFFFFFFD6, "post_wr");
    check("post_reset first word", dout, 32'hFFFFFFD6);
    cycle(0, 1, 0, '0, "post_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
